ext_rom_responder: RTL and testbench
====================================

# ext_rom_responder

External program-memory responder for the MCU51 multiplexed external bus: the memory-side end of the ALE/PSEN/P0/P2 fetch protocol. It latches the low address from P0 on ALE falling and the high address from P2. When PSEN is low, it drives the addressed code byte back onto P0. It sits outside the MCU core on the board-level bus and is used in simulation and on FPGA when EA is low.

## Interface
- ROM_AW, 12, ROM address width; depth 2^ROM_AW bytes
- XRAM_AW, 8, external data RAM address width (used only with EXT_ROM_XDATA_EN)
- clk  in  1  system clock, same clock as the MCU core
- reset  in  1  one clock; reset is synchronous and active-high
- ale  in  1  address latch enable from MCU
- psen_n  in  1  program strobe, active low
- p0_in  in  8  value currently on P0
- p2_in  in  8  value currently on P2 (high address)
- p0_out  out  8  byte driven onto P0
- p0_oe  out  1  P0 drive enable (board ties P0 = p0_oe ? p0_out : z)
- load_en  in  1  preload write strobe
- load_addr  in  ROM_AW  preload address
- load_data  in  8  preload byte
- addr_q  out  16  latched bus address (debug/visibility)
- rd_n, wr_n  in  1 each  MOVX strobes (present only with EXT_ROM_XDATA_EN)

## Operation
- All strobes are sampled on clk and registered once. An edge is detected as the registered value differing from the current sample.
- FSM states:
  - IDLE: no address held.
  - LATCHED: address held.
  - READ: memory read in flight.
  - DRIVE: P0 driven.
  - WRITE: XDATA only.
- Transitions:
  - From any state, ale sampled high → IDLE. This aborts any drive, and p0_oe drops at the next edge.
  - ALE falling (ale_q=1, ale=0): addr_q ← {p2_q, p0_q}, using P0 and P2 as sampled in the last ALE-high cycle; → LATCHED.
  - LATCHED with psen_n=0:
    - If addr_q[15:ROM_AW]==0 → READ.
    - Otherwise stay in LATCHED and never drive (address out of range; another device may respond).
  - READ → DRIVE unconditionally: p0_out ← rom[addr_q], p0_oe ← 1.
  - DRIVE with psen_n=1 → LATCHED, p0_oe ← 0.
  - A further PSEN pulse without a new ALE re-drives the same address.
- psen_n low in IDLE is ignored.
- load_en writes rom[load_addr] in any state. A same-cycle read of that address returns the old byte (read-before-write).
- Reset:
  - Outputs: p0_oe=0, p0_out=8'h00, addr_q=16'h0000.
  - State → IDLE.
  - Memory contents are not cleared, including a reset that arrives mid-drive.

## Timing
- psen_n sampled low in cycle M (state LATCHED): memory read registered at the end of M; p0_oe=1 with valid p0_out from cycle M+2. Fetch latency is 2 clocks.
- psen_n sampled high in cycle K: p0_oe=0 from cycle K+1.
- ALE falling sampled in cycle N: addr_q valid from cycle N+1. The earliest PSEN acceptance is cycle N+1.
- p0_oe is never asserted while ale is high: ale sampled high forces p0_oe=0 at the next edge.

## Configuration
- EXT_ROM_XDATA_EN defined:
  - Adds the rd_n and wr_n ports and an XRAM of 2^XRAM_AW bytes, addressed by addr_q[XRAM_AW-1:0].
  - LATCHED with rd_n=0 follows the same READ→DRIVE path, using XRAM instead of ROM, with the same 2-clock latency.
  - LATCHED with wr_n=0 → WRITE. On the wr_n rising edge, xram[addr] ← p0_q and the FSM returns to LATCHED. p0_oe stays 0 throughout a write.
  - If psen_n and rd_n are low in the same cycle, psen_n wins.
- EXT_ROM_XDATA_EN undefined: no rd_n/wr_n ports, no XRAM, and the WRITE state is not present.

## Structure
- Package ext_bus_pkg holds:
  - the FSM state enum;
  - ADDR_W=16 and DATA_W=8;
  - the idle-drive constant 8'h00.
- Sub-module byte_ram_sync: single-port-write, synchronous-read byte array parameterised by address width. It is instantiated once for ROM and once for XRAM (XDATA build).

## Test plan
- Preload rom[12'h034]=8'hA5; ALE pulse with P2=8'h00, P0=8'h34, then psen_n low → p0_oe=1, p0_out=8'hA5 two clocks after psen_n is sampled low; p0_oe=0 one clock after psen_n returns high.
- Address P2=8'h10 (beyond a 4 KB ROM), psen_n low for 4 clocks → p0_oe stays 0 throughout.
- Mid-drive ALE high → p0_oe=0 next clock. Then a new address 16'h0035 with rom=8'h3C → drives 8'h3C.
- Reset asserted during DRIVE → next clock p0_oe=0, addr_q=16'h0000. After reset, re-fetch 16'h0034 → still 8'hA5.
- load_en to 12'h034 with 8'h5A in the same cycle as the READ of 12'h034 → drives 8'hA5; the next fetch drives 8'h5A.
- (XDATA build) wr_n pulse at address 8'h20 with P0=8'h77, then rd_n low → p0_out=8'h77 after 2 clocks; psen_n and rd_n low together → ROM byte driven.

Source files
------------

// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the MCU51 external-bus responder.
// EXT_ROM_XDATA_EN adds the WRITE state used by MOVX stores.
package ext_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // Value parked on p0_out whenever P0 is not being driven.
  localparam logic [DATA_W-1:0] IDLE_DRIVE = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StLatched,
    StRead,
    StDrive
`ifdef EXT_ROM_XDATA_EN
    , StWrite
`endif
  } bus_state_e;

endpackage

// File: rtl/byte_ram_sync.sv
// Byte array with one synchronous write port and one registered read port.
// A read and write to the same address in one cycle return the old byte.
module byte_ram_sync #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/ext_rom_responder.sv
// Memory-side responder for the ALE/PSEN/P0/P2 code-fetch bus.
// EXT_ROM_XDATA_EN adds rd_n/wr_n and an XRAM answering MOVX cycles.
module ext_rom_responder
  import ext_bus_pkg::*;
#(
  parameter int unsigned ROM_AW = 12
`ifdef EXT_ROM_XDATA_EN
  , parameter int unsigned XRAM_AW = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ale,
  input  logic              psen_n,
  input  logic [DATA_W-1:0] p0_in,
  input  logic [DATA_W-1:0] p2_in,
  output logic [DATA_W-1:0] p0_out,
  output logic              p0_oe,
  input  logic              load_en,
  input  logic [ROM_AW-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] addr_q
`ifdef EXT_ROM_XDATA_EN
  , input logic             rd_n
  , input logic             wr_n
`endif
);

  bus_state_e        state_q, state_d;
  logic              ale_q;
  logic [DATA_W-1:0] p0_q, p2_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] p0_out_d;
  logic              p0_oe_d;
  logic              ale_fall;
  logic              in_range;
  logic              strobe_released;
  logic [DATA_W-1:0] rd_byte;
  logic [DATA_W-1:0] rom_rdata;

  byte_ram_sync #(
    .AW(ROM_AW),
    .DW(DATA_W)
  ) u_rom (
    .clk_i  (clk),
    .we_i   (load_en),
    .waddr_i(load_addr),
    .wdata_i(load_data),
    .raddr_i(addr_q[ROM_AW-1:0]),
    .rdata_o(rom_rdata)
  );

`ifdef EXT_ROM_XDATA_EN
  logic              wr_n_q;
  logic              sel_xram_q, sel_xram_d;
  logic              xram_we;
  logic [DATA_W-1:0] xram_rdata;

  byte_ram_sync #(
    .AW(XRAM_AW),
    .DW(DATA_W)
  ) u_xram (
    .clk_i  (clk),
    .we_i   (xram_we),
    .waddr_i(addr_q[XRAM_AW-1:0]),
    .wdata_i(p0_q),
    .raddr_i(addr_q[XRAM_AW-1:0]),
    .rdata_o(xram_rdata)
  );

  assign rd_byte         = sel_xram_q ? xram_rdata : rom_rdata;
  // A drive ends when whichever strobe started it goes back high.
  assign strobe_released = sel_xram_q ? rd_n : psen_n;
`else
  assign rd_byte         = rom_rdata;
  assign strobe_released = psen_n;
`endif

  assign ale_fall = ale_q & ~ale;
  assign in_range = (addr_q >> ROM_AW) == '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef EXT_ROM_XDATA_EN
    sel_xram_d = sel_xram_q;
    xram_we    = 1'b0;
`endif
    if (ale) begin
      state_d = StIdle;
    end else if (ale_fall) begin
      addr_d  = {p2_q, p0_q};
      state_d = StLatched;
    end else begin
      case (state_q)
        StLatched: begin
          if (!psen_n) begin
            // Out-of-range fetches are left for another device on the bus.
            if (in_range) begin
              state_d = StRead;
`ifdef EXT_ROM_XDATA_EN
              sel_xram_d = 1'b0;
`endif
            end
`ifdef EXT_ROM_XDATA_EN
          end else if (!rd_n) begin
            state_d    = StRead;
            sel_xram_d = 1'b1;
          end else if (!wr_n) begin
            state_d = StWrite;
`endif
          end
        end
        StRead:  state_d = StDrive;
        StDrive: if (strobe_released) state_d = StLatched;
`ifdef EXT_ROM_XDATA_EN
        StWrite: begin
          if (!wr_n_q && wr_n) begin
            xram_we = 1'b1;
            state_d = StLatched;
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end

    p0_oe_d  = (state_d == StDrive);
    p0_out_d = IDLE_DRIVE;
    if (state_d == StDrive) begin
      p0_out_d = (state_q == StRead) ? rd_byte : p0_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ale_q   <= 1'b0;
      p0_q    <= '0;
      p2_q    <= '0;
      addr_q  <= '0;
      p0_out  <= IDLE_DRIVE;
      p0_oe   <= 1'b0;
`ifdef EXT_ROM_XDATA_EN
      wr_n_q     <= 1'b1;
      sel_xram_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ale_q   <= ale;
      p0_q    <= p0_in;
      p2_q    <= p2_in;
      addr_q  <= addr_d;
      p0_out  <= p0_out_d;
      p0_oe   <= p0_oe_d;
`ifdef EXT_ROM_XDATA_EN
      wr_n_q     <= wr_n;
      sel_xram_q <= sel_xram_d;
`endif
    end
  end

endmodule

// File: tb/tb_ext_rom_responder.sv
// Scoreboard bench for ext_rom_responder: stimulus queues expected drives,
// a negedge monitor checks every P0 drive for value and cycle.
module tb_ext_rom_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ale = 1'b0;
  logic        psen_n = 1'b1;
  logic [7:0]  p0_in = 8'h00;
  logic [7:0]  p2_in = 8'h00;
  logic [7:0]  p0_out;
  logic        p0_oe;
  logic        load_en = 1'b0;
  logic [11:0] load_addr = 12'h000;
  logic [7:0]  load_data = 8'h00;
  logic [15:0] addr_q;
`ifdef EXT_ROM_XDATA_EN
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
`endif

  ext_rom_responder #(
    .ROM_AW(12)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ale      (ale),
    .psen_n   (psen_n),
    .p0_in    (p0_in),
    .p2_in    (p2_in),
    .p0_out   (p0_out),
    .p0_oe    (p0_oe),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .addr_q   (addr_q)
`ifdef EXT_ROM_XDATA_EN
    , .rd_n   (rd_n)
    , .wr_n   (wr_n)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: every rising p0_oe must match the head of the scoreboard.
  initial begin
    logic oe_prev;
    logic ale_prev;
    exp_t e;
    oe_prev  = 1'b0;
    ale_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (p0_oe === 1'b1 && oe_prev !== 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_drive: p0_out=%h at cycle %0d, no drive expected", p0_out, cyc);
        end else begin
          e = sb.pop_front();
          if (p0_out !== e.data || cyc != e.cyc) begin
            fails++;
            $display("FAIL drive: got %h at cycle %0d, want %h at cycle %0d",
                     p0_out, cyc, e.data, e.cyc);
          end
        end
      end
      if (ale_prev) begin
        tests++;
        if (p0_oe !== 1'b0) begin
          fails++;
          $display("FAIL oe_after_ale: p0_oe=%b, want 0 at cycle %0d", p0_oe, cyc);
        end
      end
      oe_prev  = p0_oe;
      ale_prev = ale;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick(1);
    load_en = 1'b0;
  endtask

  task automatic ale_pulse(input logic [15:0] a);
    ale = 1'b1; p2_in = a[15:8]; p0_in = a[7:0];
    tick(1);
    ale = 1'b0;
    tick(1);
    p0_in = 8'hFF;
    check("addr_latch", addr_q, a);
  endtask

  task automatic fetch(input logic [7:0] exp);
    psen_n = 1'b0;
    sb.push_back('{data: exp, cyc: cyc + 2});
    tick(3);
    check("oe_held", {15'd0, p0_oe}, 16'd1);
    psen_n = 1'b1;
    tick(1);
    check("oe_release", {15'd0, p0_oe}, 16'd0);
  endtask

  initial begin
    tick(2);
    check("rst_oe", {15'd0, p0_oe}, 16'd0);
    check("rst_p0_out", {8'd0, p0_out}, 16'h0000);
    check("rst_addr", addr_q, 16'h0000);
    reset = 1'b0;
    tick(1);

    load(12'h034, 8'hA5);
    load(12'h035, 8'h3C);
    load(12'hFFF, 8'hC3);

    // Basic fetch, then the top byte of the ROM.
    ale_pulse(16'h0034);
    fetch(8'hA5);
    ale_pulse(16'h0FFF);
    fetch(8'hC3);

    // Beyond the 4 KB ROM: never drive.
    ale_pulse(16'h1034);
    psen_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("oe_out_of_range", {15'd0, p0_oe}, 16'd0);
    end
    psen_n = 1'b1;
    tick(1);

    // ALE mid-drive aborts, then a new address drives its byte.
    ale_pulse(16'h0034);
    psen_n = 1'b0;
    sb.push_back('{data: 8'hA5, cyc: cyc + 2});
    tick(3);
    check("oe_before_abort", {15'd0, p0_oe}, 16'd1);
    ale = 1'b1; psen_n = 1'b1; p2_in = 8'h00; p0_in = 8'h35;
    tick(1);
    check("oe_abort", {15'd0, p0_oe}, 16'd0);
    ale = 1'b0;
    tick(1);
    check("addr_after_abort", addr_q, 16'h0035);
    fetch(8'h3C);

    // Reset mid-drive clears outputs but not the ROM.
    ale_pulse(16'h0034);
    psen_n = 1'b0;
    sb.push_back('{data: 8'hA5, cyc: cyc + 2});
    tick(3);
    reset = 1'b1;
    tick(1);
    check("oe_reset_mid_drive", {15'd0, p0_oe}, 16'd0);
    check("addr_reset_mid_drive", addr_q, 16'h0000);
    reset = 1'b0; psen_n = 1'b1;
    tick(1);
    ale_pulse(16'h0034);
    fetch(8'hA5);

    // Preload in the read cycle returns the old byte; a re-drive sees the new one.
    ale_pulse(16'h0034);
    psen_n = 1'b0;
    load_en = 1'b1; load_addr = 12'h034; load_data = 8'h5A;
    sb.push_back('{data: 8'hA5, cyc: cyc + 2});
    tick(1);
    load_en = 1'b0;
    tick(2);
    psen_n = 1'b1;
    tick(1);
    fetch(8'h5A);

`ifdef EXT_ROM_XDATA_EN
    ale_pulse(16'h0020);
    wr_n = 1'b0; p0_in = 8'h77;
    tick(2);
    check("oe_during_write", {15'd0, p0_oe}, 16'd0);
    wr_n = 1'b1;
    tick(2);
    check("oe_after_write", {15'd0, p0_oe}, 16'd0);
    rd_n = 1'b0;
    sb.push_back('{data: 8'h77, cyc: cyc + 2});
    tick(3);
    rd_n = 1'b1;
    tick(1);
    check("oe_after_rd", {15'd0, p0_oe}, 16'd0);
    ale_pulse(16'h0034);
    rd_n = 1'b0;
    fetch(8'h5A);
    rd_n = 1'b1;
    tick(1);
`endif

    tick(3);
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
